axi_master_arbiter: RTL and testbench



---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_master_arbiter_if.sv | 57 +++++
 rtl/axi_master_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the arbiter FSM state encoding.
package axi_pkg;

  localparam int AXI_ID_W  = 4;
  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_W     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    IFU_AR,
    IFU_R,
    LSU_AR,
    LSU_R,
    LSU_AWW,
    LSU_B
  } arb_state_e;

endpackage

// File: rtl/axi_master_arbiter_if.sv
// AXI4 bus between the arbiter (master) and the SoC interconnect (slave).
interface axi_master_arbiter_if
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  awvalid, awready;
  logic [AXI_ID_W-1:0]   awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid, wready, wlast;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid, bready;
  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  arvalid, arready;
  logic [AXI_ID_W-1:0]   arid;
  logic [ADDR_W-1:0]     araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid, rready, rlast;
  logic [AXI_ID_W-1:0]   rid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_master_arbiter.sv
// Single-outstanding arbiter: IFU reads, LSU reads and LSU writes share one AXI4 master port.
module axi_master_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                ifu_rready,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  input  logic                lsu_bready,
  axi_master_arbiter_if.master io_master
);

  arb_state_e          state_q, state_d;
  logic                last_lsu_q, last_lsu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic unused_resp_fields;
  assign unused_resp_fields = ^{io_master.rid, io_master.bid, io_master.rlast};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Master-side valids come only from state and done flags.
  assign io_master.arvalid = (state_q == IFU_AR) || (state_q == LSU_AR);
  assign io_master.awvalid = (state_q == LSU_AWW) && !aw_done_q;
  assign io_master.wvalid  = (state_q == LSU_AWW) && !w_done_q;
  assign io_master.wlast   = io_master.wvalid;

  assign io_master.arid    = '0;
  assign io_master.arlen   = '0;
  assign io_master.arburst = AXI_BURST_INCR;
  assign io_master.araddr  = addr_q;
  assign io_master.arsize  = size_q;
  assign io_master.awid    = '0;
  assign io_master.awlen   = '0;
  assign io_master.awburst = AXI_BURST_INCR;
  assign io_master.awaddr  = addr_q;
  assign io_master.awsize  = size_q;
  assign io_master.wdata   = data_q;
  assign io_master.wstrb   = strb_q;

  assign ifu_rdata = io_master.rdata;
  assign ifu_rresp = io_master.rresp;
  assign lsu_rdata = io_master.rdata;
  assign lsu_rresp = io_master.rresp;
  assign lsu_bresp = io_master.bresp;

  always_comb begin
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    addr_d     = addr_q;
    size_d     = size_q;
    data_d     = data_q;
    strb_d     = strb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_bvalid  = 1'b0;
    io_master.rready = 1'b0;
    io_master.bready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Store beats both reads; on a read tie last_lsu hands the grant to IFU.
        if (lsu_awvalid && lsu_wvalid) begin
          lsu_awready = 1'b1;
          lsu_wready  = 1'b1;
          addr_d      = lsu_awaddr;
          size_d      = lsu_awsize;
          data_d      = lsu_wdata;
          strb_d      = lsu_wstrb;
          state_d     = LSU_AWW;
        end else if (lsu_arvalid && !(ifu_arvalid && last_lsu_q)) begin
          lsu_arready = 1'b1;
          addr_d      = lsu_araddr;
          size_d      = lsu_arsize;
          last_lsu_d  = 1'b1;
          state_d     = LSU_AR;
        end else if (ifu_arvalid) begin
          ifu_arready = 1'b1;
          addr_d      = ifu_araddr;
          size_d      = AXI_SIZE_W;
          last_lsu_d  = 1'b0;
          state_d     = IFU_AR;
        end
      end
      IFU_AR: if (io_master.arready) state_d = IFU_R;
      LSU_AR: if (io_master.arready) state_d = LSU_R;
      IFU_R: begin
        io_master.rready = ifu_rready;
        ifu_rvalid       = io_master.rvalid;
        if (io_master.rvalid && ifu_rready) state_d = IDLE;
      end
      LSU_R: begin
        io_master.rready = lsu_rready;
        lsu_rvalid       = io_master.rvalid;
        if (io_master.rvalid && lsu_rready) state_d = IDLE;
      end
      LSU_AWW: begin
        aw_done_d = aw_done_q || io_master.awready;
        w_done_d  = w_done_q || io_master.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = LSU_B;
        end
      end
      LSU_B: begin
        io_master.bready = lsu_bready;
        lsu_bvalid       = io_master.bvalid;
        if (io_master.bvalid && lsu_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter; the bench plays both the core requesters and the AXI slave.
module tb_axi_master_arbiter;
  import axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [2:0]  lsu_arsize, lsu_awsize;
  logic [1:0]  lsu_rresp, lsu_bresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  axi_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .io_master(bus.master)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_awsize = '0;
    lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = '0;
    bus.arready = 0; bus.rvalid = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b1;
    tick(); tick();

    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_araddr", bus.araddr, 0);
    reset = 1'b0;

    // IFU read of 0x8000_0000, data after 3 slave cycles
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; #1;
    chk("t1_ifu_arready", ifu_arready, 1);
    chk("t1_lsu_arready", lsu_arready, 0);
    tick(); ifu_arvalid = 0; #1;
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h8000_0000);
    chk("t1_arsize", bus.arsize, 2);
    chk("t1_arlen", bus.arlen, 0);
    chk("t1_arburst", bus.arburst, 1);
    chk("t1_arid", bus.arid, 0);
    bus.arready = 1; tick(); bus.arready = 0; #1;
    chk("t1_arvalid_drop", bus.arvalid, 0);
    ifu_rready = 1; tick(); tick(); tick();
    chk("t1_no_early_rvalid", ifu_rvalid, 0);
    bus.rvalid = 1; bus.rdata = 32'h0000_0413; bus.rresp = 2'b00; #1;
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    chk("t1_rready", bus.rready, 1);
    tick(); bus.rvalid = 0; ifu_rready = 0; #1;
    chk("t1_idle_rready", bus.rready, 0);

    // Read tie: LSU first, then the next tie goes to IFU
    ifu_arvalid = 1; ifu_araddr = 32'h100;
    lsu_arvalid = 1; lsu_araddr = 32'h200; lsu_arsize = 3'd0; #1;
    chk("t2_lsu_arready", lsu_arready, 1);
    chk("t2_ifu_arready", ifu_arready, 0);
    tick(); lsu_arvalid = 0; #1;
    chk("t2_araddr", bus.araddr, 32'h200);
    chk("t2_arsize", bus.arsize, 0);
    chk("t2_ifu_blocked_ar", ifu_arready, 0);
    bus.arready = 1; tick(); bus.arready = 0;
    lsu_rready = 1; bus.rvalid = 1; bus.rdata = 32'hAAAA_5555; #1;
    chk("t2_lsu_rvalid", lsu_rvalid, 1);
    chk("t2_lsu_rdata", lsu_rdata, 32'hAAAA_5555);
    chk("t2_ifu_rvalid_nonowner", ifu_rvalid, 0);
    chk("t2_ifu_blocked_r", ifu_arready, 0);
    tick(); bus.rvalid = 0; lsu_rready = 0;
    lsu_arvalid = 1; lsu_araddr = 32'h300; lsu_arsize = 3'd1; #1;
    chk("t2_tie2_ifu_arready", ifu_arready, 1);
    chk("t2_tie2_lsu_arready", lsu_arready, 0);
    tick(); ifu_arvalid = 0; #1;
    chk("t2_ifu_araddr", bus.araddr, 32'h100);
    chk("t2_ifu_arsize", bus.arsize, 2);
    bus.arready = 1; tick(); bus.arready = 0;
    ifu_rready = 1; bus.rvalid = 1; bus.rdata = 32'h11; #1;
    chk("t2_ifu_rdata", ifu_rdata, 32'h11);
    chk("t2_lsu_rvalid_nonowner", lsu_rvalid, 0);
    tick(); bus.rvalid = 0; ifu_rready = 0; #1;
    chk("t2_lsu_granted", lsu_arready, 1);
    tick(); lsu_arvalid = 0; #1;
    chk("t2_lsu_araddr2", bus.araddr, 32'h300);
    bus.arready = 1; tick(); bus.arready = 0;
    lsu_rready = 1; bus.rvalid = 1; bus.rresp = 2'b10; #1;
    chk("t5_rresp_fwd", lsu_rresp, 2'b10);
    tick(); bus.rvalid = 0; bus.rresp = 2'b00; lsu_rready = 0;

    // Lone AW without W is not granted
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0004; lsu_awsize = 3'd2; #1;
    chk("t3_lone_aw_ready", lsu_awready, 0);
    tick();
    chk("t3_lone_aw_no_master", bus.awvalid, 0);

    // Store with concurrent IFU request; W accepted 2 cycles before AW
    lsu_wvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
    ifu_arvalid = 1; ifu_araddr = 32'h400; #1;
    chk("t3_awready", lsu_awready, 1);
    chk("t3_wready", lsu_wready, 1);
    chk("t4_ifu_arready_store", ifu_arready, 0);
    tick(); lsu_awvalid = 0; lsu_wvalid = 0; #1;
    chk("t3_awvalid", bus.awvalid, 1);
    chk("t3_wvalid", bus.wvalid, 1);
    chk("t3_awaddr", bus.awaddr, 32'h8000_0004);
    chk("t3_wdata", bus.wdata, 32'h1234_5678);
    chk("t3_wstrb", bus.wstrb, 4'hF);
    chk("t3_wlast", bus.wlast, 1);
    chk("t3_awsize", bus.awsize, 2);
    chk("t3_awburst", bus.awburst, 1);
    chk("t3_awlen", bus.awlen, 0);
    bus.wready = 1; tick(); bus.wready = 0; #1;
    chk("t3_wvalid_drop", bus.wvalid, 0);
    chk("t3_wlast_drop", bus.wlast, 0);
    chk("t3_awvalid_held", bus.awvalid, 1);
    tick();
    chk("t3_awvalid_held2", bus.awvalid, 1);
    chk("t3_no_early_bready", bus.bready, 0);
    bus.awready = 1; tick(); bus.awready = 0;
    lsu_bready = 1; #1;
    chk("t3_awvalid_drop", bus.awvalid, 0);
    chk("t3_bready", bus.bready, 1);
    chk("t3_no_early_bvalid", lsu_bvalid, 0);
    chk("t4_ifu_blocked_b", ifu_arready, 0);
    bus.bvalid = 1; bus.bresp = 2'b11; #1;
    chk("t3_lsu_bvalid", lsu_bvalid, 1);
    chk("t5_bresp_fwd", lsu_bresp, 2'b11);
    tick(); bus.bvalid = 0; bus.bresp = 2'b00; lsu_bready = 0;
    ifu_rready = 1; bus.rvalid = 1; bus.rdata = 32'hDEAD; #1;
    chk("t5_spurious_ifu_rvalid", ifu_rvalid, 0);
    chk("t5_spurious_lsu_rvalid", lsu_rvalid, 0);
    chk("t5_spurious_rready", bus.rready, 0);
    chk("t4_ifu_after_b", ifu_arready, 1);
    bus.rvalid = 0;
    tick(); ifu_arvalid = 0; #1;
    chk("t4_ifu_araddr", bus.araddr, 32'h400);
    bus.arready = 1; tick(); bus.arready = 0;
    bus.rvalid = 1; bus.rdata = 32'h99; #1;
    chk("t4_ifu_rdata", ifu_rdata, 32'h99);
    tick(); bus.rvalid = 0; ifu_rready = 0;

    // Reset while AW is held in LSU_AWW
    lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h50; lsu_wdata = 32'h5;
    tick(); lsu_awvalid = 0; lsu_wvalid = 0; #1;
    chk("t6_awvalid_pre", bus.awvalid, 1);
    reset = 1; tick(); reset = 0; #1;
    chk("t6_awvalid_rst", bus.awvalid, 0);
    chk("t6_wvalid_rst", bus.wvalid, 0);
    chk("t6_arvalid_rst", bus.arvalid, 0);
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0010; #1;
    chk("t6_ifu_arready", ifu_arready, 1);
    tick(); ifu_arvalid = 0; #1;
    chk("t6_araddr", bus.araddr, 32'h8000_0010);
    bus.arready = 1; tick(); bus.arready = 0;
    ifu_rready = 1; bus.rvalid = 1; bus.rdata = 32'h77; #1;
    chk("t6_ifu_rvalid", ifu_rvalid, 1);
    chk("t6_ifu_rdata", ifu_rdata, 32'h77);
    tick(); bus.rvalid = 0; ifu_rready = 0;

    // Store where AW and W handshake in the same cycle
    lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h40; lsu_wdata = 32'hCAFE; lsu_wstrb = 4'h3;
    tick(); lsu_awvalid = 0; lsu_wvalid = 0;
    bus.awready = 1; bus.wready = 1; #1;
    chk("t7_wstrb", bus.wstrb, 4'h3);
    tick(); bus.awready = 0; bus.wready = 0;
    lsu_bready = 1; #1;
    chk("t7_awvalid", bus.awvalid, 0);
    chk("t7_wvalid", bus.wvalid, 0);
    chk("t7_bready", bus.bready, 1);
    bus.bvalid = 1; bus.bresp = AXI_RESP_OKAY; #1;
    chk("t7_bvalid", lsu_bvalid, 1);
    tick(); bus.bvalid = 0; lsu_bready = 0; #1;
    chk("t7_idle_bready", bus.bready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
